forw_unit_sb: RTL

//  Parametrised forwarding unit with a destination-tag scoreboard for the pipelined

---
 rtl/forw_unit_sb.sv | 100 ++++++++++
 1 files changed

// File: rtl/forw_unit_sb.sv
// forw_unit_sb: operand forwarding unit with a destination-tag scoreboard.
//   Shadows the EX..WB stages with a pipeline of {valid, wr_en, dest, is_load}
//   tags. For each ID-stage source it selects the youngest matching in-flight
//   result, or the register bank when nothing matches. It also raises a one-cycle
//   stall on load-use hazards and keeps a saturating count of stall cycles.
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   i_hold                     freeze tag pipeline and stall counter
//   i_flush                    squash the ID instruction (bubble into stage 0)
//   i_wr_en/i_is_load/i_dest   tag of the ID instruction
//   i_src_addr, i_regbnk       per-source register address / bank read data
//   i_stg_data                 result bus of each tracked stage
//   o_sel, o_operand           per-source select (0=bank, k+1=stage k) and operand
//   o_stall, o_stall_cnt       load-use stall and saturating stall-cycle count
module forw_unit_sb #(
  parameter int unsigned NBITS   = 32,
  parameter int unsigned RBITS   = 5,
  parameter int unsigned NSTG    = 3,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned SELBITS = 2,
  parameter int unsigned CNTBITS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_hold,
  input  logic                    i_flush,
  input  logic                    i_wr_en,
  input  logic                    i_is_load,
  input  logic [RBITS-1:0]        i_dest,
  input  logic [NSRC*RBITS-1:0]   i_src_addr,
  input  logic [NSRC*NBITS-1:0]   i_regbnk,
  input  logic [NSTG*NBITS-1:0]   i_stg_data,
  output logic [NSRC*SELBITS-1:0] o_sel,
  output logic [NSRC*NBITS-1:0]   o_operand,
  output logic                    o_stall,
  output logic [CNTBITS-1:0]      o_stall_cnt
);

  logic [NSTG-1:0]  tag_valid;
  logic [NSTG-1:0]  tag_wr;
  logic [NSTG-1:0]  tag_load;
  logic [RBITS-1:0] tag_dest [NSTG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid   <= '0;
      tag_wr      <= '0;
      tag_load    <= '0;
      for (int unsigned k = 0; k < NSTG; k++) tag_dest[k] <= '0;
      o_stall_cnt <= '0;
    end else if (!i_hold) begin
      for (int unsigned k = 1; k < NSTG; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_wr[k]    <= tag_wr[k-1];
        tag_load[k]  <= tag_load[k-1];
        tag_dest[k]  <= tag_dest[k-1];
      end
      // A stalled ID instruction is replayed next cycle, so it enters as a bubble.
      if (i_flush || o_stall) begin
        tag_valid[0] <= 1'b0;
        tag_wr[0]    <= 1'b0;
        tag_load[0]  <= 1'b0;
        tag_dest[0]  <= '0;
      end else begin
        tag_valid[0] <= 1'b1;
        tag_wr[0]    <= i_wr_en;
        tag_load[0]  <= i_is_load;
        tag_dest[0]  <= i_dest;
      end
      if (o_stall && (o_stall_cnt != '1))
        o_stall_cnt <= o_stall_cnt + CNTBITS'(1);
    end
  end

  always_comb begin
    logic [RBITS-1:0]   src;
    logic [SELBITS-1:0] sel;
    logic               found;
    o_sel     = '0;
    o_operand = '0;
    o_stall   = 1'b0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      src   = i_src_addr[s*RBITS +: RBITS];
      sel   = '0;
      found = 1'b0;
      o_operand[s*NBITS +: NBITS] = i_regbnk[s*NBITS +: NBITS];
      // Scan from stage 0 upward: the first hit is the youngest producer.
      for (int unsigned k = 0; k < NSTG; k++) begin
        if (!found && tag_valid[k] && tag_wr[k] && (tag_dest[k] == src) && (src != '0)) begin
          found = 1'b1;
          sel   = SELBITS'(k + 1);
          o_operand[s*NBITS +: NBITS] = i_stg_data[k*NBITS +: NBITS];
          if (k == 0 && tag_load[0]) o_stall = 1'b1;
        end
      end
      o_sel[s*SELBITS +: SELBITS] = sel;
    end
  end

endmodule
